// File: rtl/fir_input_arbiter.sv
// Round-robin arbiter sharing one FIR sample input between two valid/ready requesters,
// with an owner tag pipeline matching the FIR latency. Optional grant counters: FIR_ARB_STATS_EN.
module fir_input_arbiter #(
    parameter int DATA_W      = 8,
    parameter int SAMPLE_GAP  = 4,
    parameter int FIR_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              req2_valid,
    input  logic [DATA_W-1:0] req2_data,
    output logic              req2_ready,
    output logic [DATA_W-1:0] fir_data,
    output logic              fir_pe_n,
    input  logic [DATA_W-1:0] fir_out_i,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              result_owner
`ifdef FIR_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       grant_cnt2
`endif
);

    localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SAMPLE_GAP - 1);

    logic [GAP_W-1:0]       gap_cnt_reg;
    logic                   last_grant_reg;   // 0 = requester 1, 1 = requester 2
    logic [DATA_W-1:0]      fir_data_reg;
    logic                   fir_pe_n_reg;
    logic                   issue_owner_reg;
    logic [FIR_LATENCY-1:0] tag_valid_reg;
    logic [FIR_LATENCY-1:0] tag_owner_reg;
    logic [FIR_LATENCY-1:0] tag_valid_next;
    logic [FIR_LATENCY-1:0] tag_owner_next;
    logic                   result_valid_reg;
    logic [DATA_W-1:0]      result_data_reg;
    logic                   result_owner_reg;
    logic                   grant1;
    logic                   grant2;
    logic                   xfer_any;

    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (gap_cnt_reg == '0) begin
            // On contention the requester that did not win last time gets the slot
            if (req1_valid && req2_valid) begin
                if (last_grant_reg) begin
                    grant1 = 1'b1;
                end else begin
                    grant2 = 1'b1;
                end
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end else if (req2_valid) begin
                grant2 = 1'b1;
            end
        end
    end

    assign req1_ready = grant1;
    assign req2_ready = grant2;
    assign xfer_any   = grant1 | grant2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt_reg     <= '0;
            last_grant_reg  <= 1'b1;
            fir_data_reg    <= '0;
            fir_pe_n_reg    <= 1'b1;
            issue_owner_reg <= 1'b0;
        end else begin
            if (xfer_any) begin
                gap_cnt_reg     <= GAP_RELOAD;
                fir_data_reg    <= grant1 ? req1_data : req2_data;
                issue_owner_reg <= grant2;
                last_grant_reg  <= grant2;
            end else if (gap_cnt_reg != '0) begin
                gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            end
            fir_pe_n_reg <= ~xfer_any;
        end
    end

    // Tag enters on the strobe cycle and reaches the last stage when fir_out_i is valid
    genvar gi;
    generate
        for (gi = 0; gi < FIR_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = ~fir_pe_n_reg;
                assign tag_owner_next[gi] = issue_owner_reg;
            end else begin : g_body
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_owner_next[gi] = tag_owner_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid_reg    <= '0;
            tag_owner_reg    <= '0;
            result_valid_reg <= 1'b0;
            result_data_reg  <= '0;
            result_owner_reg <= 1'b0;
        end else begin
            tag_valid_reg    <= tag_valid_next;
            tag_owner_reg    <= tag_owner_next;
            result_valid_reg <= tag_valid_reg[FIR_LATENCY-1];
            if (tag_valid_reg[FIR_LATENCY-1]) begin
                result_data_reg  <= fir_out_i;
                result_owner_reg <= tag_owner_reg[FIR_LATENCY-1];
            end
        end
    end

    assign fir_data     = fir_data_reg;
    assign fir_pe_n     = fir_pe_n_reg;
    assign result_valid = result_valid_reg;
    assign result_data  = result_data_reg;
    assign result_owner = result_owner_reg;

`ifdef FIR_ARB_STATS_EN
    logic [15:0] grant_cnt1_reg;
    logic [15:0] grant_cnt2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt1_reg <= '0;
            grant_cnt2_reg <= '0;
        end else begin
            if (grant1 && (grant_cnt1_reg != 16'hFFFF)) begin
                grant_cnt1_reg <= grant_cnt1_reg + 16'd1;
            end
            if (grant2 && (grant_cnt2_reg != 16'hFFFF)) begin
                grant_cnt2_reg <= grant_cnt2_reg + 16'd1;
            end
        end
    end

    assign grant_cnt1 = grant_cnt1_reg;
    assign grant_cnt2 = grant_cnt2_reg;
`endif

endmodule

// File: tb/tb_fir_input_arbiter.sv
// Bench for fir_input_arbiter: behavioural model checks a default-parameter instance every
// cycle; a SAMPLE_GAP=1 instance is checked with literal expectations.
module tb_fir_input_arbiter;

    localparam int GAP_A = 4;
    localparam int LAT   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fir_out_i = 8'h00;

    logic       req1_valid = 1'b0, req2_valid = 1'b0;
    logic [7:0] req1_data = 8'h00, req2_data = 8'h00;
    logic       req1_ready, req2_ready, fir_pe_n, result_valid, result_owner;
    logic [7:0] fir_data, result_data;

    logic       b_req1_valid = 1'b0, b_req2_valid = 1'b0;
    logic [7:0] b_req1_data = 8'h00, b_req2_data = 8'h00;
    logic       b_req1_ready, b_req2_ready, b_fir_pe_n, b_result_valid, b_result_owner;
    logic [7:0] b_fir_data, b_result_data;

`ifdef FIR_ARB_STATS_EN
    logic [15:0] grant_cnt1, grant_cnt2, b_grant_cnt1, b_grant_cnt2;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_input_arbiter #(.DATA_W(8), .SAMPLE_GAP(GAP_A), .FIR_LATENCY(LAT)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .req2_valid(req2_valid), .req2_data(req2_data), .req2_ready(req2_ready),
        .fir_data(fir_data), .fir_pe_n(fir_pe_n), .fir_out_i(fir_out_i),
        .result_valid(result_valid), .result_data(result_data), .result_owner(result_owner)
`ifdef FIR_ARB_STATS_EN
        , .grant_cnt1(grant_cnt1), .grant_cnt2(grant_cnt2)
`endif
    );

    fir_input_arbiter #(.DATA_W(8), .SAMPLE_GAP(1), .FIR_LATENCY(LAT)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .req2_valid(b_req2_valid), .req2_data(b_req2_data), .req2_ready(b_req2_ready),
        .fir_data(b_fir_data), .fir_pe_n(b_fir_pe_n), .fir_out_i(fir_out_i),
        .result_valid(b_result_valid), .result_data(b_result_data), .result_owner(b_result_owner)
`ifdef FIR_ARB_STATS_EN
        , .grant_cnt1(b_grant_cnt1), .grant_cnt2(b_grant_cnt2)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    endtask

    // ---------------- behavioural model of instance A ----------------
    typedef struct { int due; bit owner; } res_t;
    res_t       exp_q[$];
    bit         armed = 0, just_reset = 0, has_xfer = 0;
    int         last_xfer = 0;
    bit         last_owner = 1;   // requester 2 "won last" after reset
    logic [7:0] m_fir_data = 8'h00;
    logic [7:0] prev_fo = 8'h00;

    always @(negedge clk) begin
        bit open, g1, g2, exp_rv;
        open = !has_xfer || ((cyc - last_xfer) >= GAP_A);
        g1 = 0; g2 = 0;
        if (open) begin
            if (req1_valid && req2_valid) begin
                g1 = (last_owner == 1);
                g2 = (last_owner == 0);
            end else begin
                g1 = req1_valid;
                g2 = req2_valid && !req1_valid;
            end
        end
        if (armed) begin
            exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("m_fir_pe_n", {15'd0, fir_pe_n}, {15'd0, !(has_xfer && last_xfer == cyc - 1)});
            chk("m_fir_data", {8'd0, fir_data}, {8'd0, m_fir_data});
            chk("m_result_valid", {15'd0, result_valid}, {15'd0, exp_rv});
            if (exp_rv) begin
                chk("m_result_data", {8'd0, result_data}, {8'd0, prev_fo});
                chk("m_result_owner", {15'd0, result_owner}, {15'd0, exp_q[0].owner});
                void'(exp_q.pop_front());
            end
            if (just_reset) begin
                chk("m_rst_result_data", {8'd0, result_data}, 16'd0);
                chk("m_rst_result_owner", {15'd0, result_owner}, 16'd0);
            end
            if (rst_n) begin
                chk("m_req1_ready", {15'd0, req1_ready}, {15'd0, g1});
                chk("m_req2_ready", {15'd0, req2_ready}, {15'd0, g2});
            end
        end
        if (!rst_n) begin
            has_xfer = 0; last_owner = 1; m_fir_data = 8'h00;
            exp_q.delete(); armed = 1; just_reset = 1;
        end else begin
            just_reset = 0;
            if (armed && (g1 || g2)) begin
                has_xfer   = 1;
                last_xfer  = cyc;
                last_owner = g2;
                m_fir_data = g1 ? req1_data : req2_data;
                exp_q.push_back('{due: cyc + 2 + LAT, owner: g2});
            end
        end
        prev_fo = fir_out_i;
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rn, input logic v1, input logic [7:0] d1,
                        input logic v2, input logic [7:0] d2, input logic [7:0] fo);
        @(posedge clk); #1;
        rst_n = rn; fir_out_i = fo;
        req1_valid = v1; req1_data = d1; req2_valid = v2; req2_data = d2;
        b_req1_valid = 0; b_req2_valid = 0;
        @(negedge clk);
    endtask

    task automatic bstep(input logic rn, input logic v1, input logic [7:0] d1,
                         input logic v2, input logic [7:0] d2, input logic [7:0] fo);
        @(posedge clk); #1;
        rst_n = rn; fir_out_i = fo;
        b_req1_valid = v1; b_req1_data = d1; b_req2_valid = v2; b_req2_data = d2;
        req1_valid = 0; req2_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        // reset
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_fir_pe_n", {15'd0, fir_pe_n}, 16'd1);
        chk("rst_fir_data", {8'd0, fir_data}, 16'd0);
        chk("rst_result_valid", {15'd0, result_valid}, 16'd0);

        // single req1 transfer and its result
        step(1, 1, 8'h25, 0, 0, 8'h11);
        chk("s1_req1_ready", {15'd0, req1_ready}, 16'd1);
        chk("s1_req2_ready", {15'd0, req2_ready}, 16'd0);
        step(1, 0, 0, 0, 0, 8'h12);
        chk("s1_fir_data", {8'd0, fir_data}, 16'h25);
        chk("s1_pe_low", {15'd0, fir_pe_n}, 16'd0);
        step(1, 0, 0, 0, 0, 8'h13);
        chk("s1_pe_high", {15'd0, fir_pe_n}, 16'd1);
        step(1, 0, 0, 0, 0, 8'h14);
        step(1, 0, 0, 0, 0, 8'h5C);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("s1_result_valid", {15'd0, result_valid}, 16'd1);
        chk("s1_result_data", {8'd0, result_data}, 16'h5C);
        chk("s1_result_owner", {15'd0, result_owner}, 16'd0);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("s1_result_pulse", {15'd0, result_valid}, 16'd0);

        // continuous dual requests after reset: 1,2,1,2 every SAMPLE_GAP cycles
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 8'h30 + 8'(i), 1, 8'h60 + 8'(i), 8'h80 + 8'(i));
            chk("s2_req1_ready", {15'd0, req1_ready}, {15'd0, (i % 8) == 0});
            chk("s2_req2_ready", {15'd0, req2_ready}, {15'd0, (i % 8) == 4});
        end
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 8'hC0 + 8'(i));

        // req1 pulse during gap must not be taken nor disturb last_grant
        step(1, 0, 0, 1, 8'h71, 8'h01);
        chk("s3_req2_ready", {15'd0, req2_ready}, 16'd1);
        step(1, 1, 8'h72, 0, 0, 8'h02);
        chk("s3_pulse_ready", {15'd0, req1_ready}, 16'd0);
        step(1, 0, 0, 0, 0, 8'h03);
        chk("s3_pe_n", {15'd0, fir_pe_n}, 16'd1);
        step(1, 0, 0, 0, 0, 8'h04);
        step(1, 1, 8'h73, 1, 8'h74, 8'h05);
        chk("s3_req1_wins", {15'd0, req1_ready}, 16'd1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 8'h10 + 8'(i));

        // reset two cycles after a strobe drops the in-flight result
        step(1, 1, 8'h9A, 0, 0, 8'h20);
        step(1, 0, 0, 0, 0, 8'h21);
        step(1, 0, 0, 0, 0, 8'h22);
        step(0, 0, 0, 0, 0, 8'h23);
        step(1, 0, 0, 0, 0, 8'h24);
        chk("s4_fir_data", {8'd0, fir_data}, 16'd0);
        step(1, 0, 0, 0, 0, 8'h25);
        chk("s4_no_result", {15'd0, result_valid}, 16'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 8'h26);

        // mixed request patterns, checked by the model
        for (int i = 0; i < 48; i++)
            step(1, (i % 3) != 0, 8'(i * 5), (i % 5) < 3, 8'(i * 11), 8'(i * 7 + 1));
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 8'h33);

        // instance with SAMPLE_GAP=1: back-to-back req2 transfers
        bstep(0, 0, 0, 0, 0, 0);
        bstep(1, 0, 0, 1, 8'h01, 8'hA0);
        chk("b_ready0", {15'd0, b_req2_ready}, 16'd1);
        bstep(1, 0, 0, 1, 8'h02, 8'hA1);
        chk("b_ready1", {15'd0, b_req2_ready}, 16'd1);
        chk("b_pe1", {15'd0, b_fir_pe_n}, 16'd0);
        chk("b_data1", {8'd0, b_fir_data}, 16'h01);
        bstep(1, 0, 0, 1, 8'h03, 8'hA2);
        chk("b_pe2", {15'd0, b_fir_pe_n}, 16'd0);
        chk("b_data2", {8'd0, b_fir_data}, 16'h02);
        bstep(1, 0, 0, 0, 0, 8'hA3);
        chk("b_pe3", {15'd0, b_fir_pe_n}, 16'd0);
        chk("b_data3", {8'd0, b_fir_data}, 16'h03);
        bstep(1, 0, 0, 0, 0, 8'hA4);
        chk("b_pe4", {15'd0, b_fir_pe_n}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            bstep(1, 0, 0, 0, 0, 8'hA5 + 8'(i));
            chk("b_result_valid", {15'd0, b_result_valid}, 16'd1);
            chk("b_result_data", {8'd0, b_result_data}, {8'd0, 8'hA4 + 8'(i)});
            chk("b_result_owner", {15'd0, b_result_owner}, 16'd1);
        end
        bstep(1, 0, 0, 0, 0, 8'h00);
        chk("b_result_end", {15'd0, b_result_valid}, 16'd0);

`ifdef FIR_ARB_STATS_EN
        chk("b_cnt2_small", b_grant_cnt2, 16'd3);
        chk("b_cnt1_zero", b_grant_cnt1, 16'd0);
        bstep(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) bstep(1, 1, 8'(i), 0, 0, 0);
        bstep(1, 0, 0, 0, 0, 0);
        chk("b_cnt1_sat", b_grant_cnt1, 16'hFFFF);
        chk("b_cnt2_clear", b_grant_cnt2, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_input_arbiter.md
Name: fir_input_arbiter

Overview:
Shares the single FIR sample input between two requesters (the two data sources currently merged by a bitwise OR) using round-robin arbitration with valid/ready handshakes. Each accepted sample drives the FIR data bus and fires a one-cycle active-low load strobe. Issue rate is held to the FIR's minimum sample spacing. The requester ID is tracked through the FIR latency so each filtered output comes back tagged with its owner.

Parameters:
DATA_W, 8, width of samples and FIR output
SAMPLE_GAP, 4, minimum cycles between accepted samples (legal >=1; 1 = back-to-back)
FIR_LATENCY, 3, cycles from load strobe low to the matching valid value on fir_out_i (legal >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset (sampled on clk; not asynchronous)
req1_valid  input  1  requester 1 offers a sample
req1_data  input  DATA_W  requester 1 sample
req1_ready  output  1  requester 1 sample accepted this cycle when valid also high
req2_valid  input  1  requester 2 offers a sample
req2_data  input  DATA_W  requester 2 sample
req2_ready  output  1  requester 2 sample accepted this cycle when valid also high
fir_data  output  DATA_W  sample to FIR data input
fir_pe_n  output  1  active-low one-cycle load strobe to FIR
fir_out_i  input  DATA_W  FIR filtered output
result_valid  output  1  one-cycle pulse, result_data valid
result_data  output  DATA_W  captured FIR output
result_owner  output  1  0 = requester 1, 1 = requester 2

Behaviour:
- Reset (rst_n low at a clk edge): fir_data=0, fir_pe_n=1, result_valid=0, result_data=0, result_owner=0, gap counter=0, last_grant=requester 2 (so requester 1 wins first), tag pipeline cleared. In-flight samples are dropped; no result_valid for them after reset releases.
- Gap counter: loaded with SAMPLE_GAP-1 on an accepted transfer, decrements to 0 and holds. Arbiter is open only when counter==0.
- Ready (combinational from valids, counter, last_grant): when open and one valid is high, that requester's ready=1. When both are high, ready goes to the requester not in last_grant. At most one ready is high in any cycle. Ready never depends on the requester's own ready.
- Transfer at cycle T (valid&&ready): at T+1, fir_data=accepted sample and fir_pe_n=0 for exactly one cycle. last_grant updates. Next transfer earliest at T+SAMPLE_GAP.
- fir_data holds the last sample between strobes.
- Valid deasserted before acceptance: nothing issued, no state change. Data is sampled only at transfer.
- Tag pipeline: FIR_LATENCY-deep shift of {valid,owner}, entered at strobe cycle T+1. fir_out_i is sampled at T+1+FIR_LATENCY. result_valid/result_data/result_owner are registered and appear at T+2+FIR_LATENCY for one cycle.
- Results come out in issue order. Pipeline accepts a new tag every cycle, so no overflow is possible.
- Fairness: under continuous dual requests, grants strictly alternate 1,2,1,2,...

Optional Feature:
Macro FIR_ARB_STATS_EN. When defined, adds outputs grant_cnt1 and grant_cnt2 (16 bits each). Each is a saturating count of accepted transfers per requester, holding at 16'hFFFF. Both clear on reset. When undefined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset then req1_valid=1 with data 8'h25 at cycle 0 -> req1_ready=1 at cycle 0; fir_data=8'h25 and fir_pe_n=0 at cycle 1 only; result_valid=1, result_owner=0, result_data=fir_out_i value from cycle 4, seen at cycle 5 (defaults).
- Both valid continuously, SAMPLE_GAP=4 -> transfers at cycles 0,4,8,12 with owners 1,2,1,2. Readies low on cycles 1-3, 5-7, ...
- SAMPLE_GAP=1, req2 only, valid held 3 cycles with data 1,2,3 -> fir_pe_n low on three consecutive cycles; three results in order, all owner=1.
- req1_valid pulsed high at cycle 1 while the gap counter is nonzero, then dropped -> no transfer, fir_pe_n stays 1, last_grant unchanged.
- rst_n low for one edge, 2 cycles after a strobe -> all outputs at reset values next cycle; no result_valid for the dropped sample.
- With FIR_ARB_STATS_EN: 70000 req1 transfers (SAMPLE_GAP=1) -> grant_cnt1=16'hFFFF, grant_cnt2=0.
